// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: receiver for 8N1 serial frames, sampling each bit in the middle.
// The asynchronous rx_in line is first synchronised into the rx_clk domain.
// The start bit is re-checked at its midpoint so that short low glitches are
// rejected. Data bits are taken one bit period apart, LSB first. A good stop
// bit updates d_out and pulses rx_valid. A low stop bit pulses rx_frame_err
// and the receiver waits in BREAK until the line goes high again.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       rx_clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] d_out,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);

    // Timer values at which the start check and the bit samples happen.
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic [1:0]    sync;
    logic          rx_s;
    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    // Two-flop synchroniser for the asynchronous serial line.
    // NOTE: the synchroniser resets to the idle level (1). A reset to 0 would
    // look like a start bit as soon as reset is released.
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx_in};
        end
    end

    assign rx_s = sync[1];

    // Frame state machine, bit timer, shift register and output registers.
    // NOTE: all state here is updated with non-blocking assignments, so that
    // every branch reads the values from before the clock edge.
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            timer        <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            d_out        <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            // The strobes are cleared every cycle, so each one lasts a single cycle.
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state   <= ST_START;
                        timer   <= '0;
                        bit_idx <= '0;
                    end
                end
                ST_START: begin
                    if (timer == HALF_LAST) begin
                        timer <= '0;
                        // A line that is high again at mid start bit was only a glitch.
                        state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (timer == BIT_LAST) begin
                        timer          <= '0;
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (timer == BIT_LAST) begin
                        timer <= '0;
                        if (rx_s) begin
                            d_out    <= shreg;
                            rx_valid <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= ST_BREAK;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // Wait here until the line returns high, so a held-low
                    // line cannot start a new frame.
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed testbench for uart_rx_sampler. There are two instances: one with
// 16 clocks per bit and one with 4 clocks per bit, the minimum. Both share the
// clock and the reset. Inputs change on the falling edge of the clock and
// outputs are sampled on the falling edge.
module tb_uart_rx_sampler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rx4;
    logic [7:0] d_out, d_out4;
    logic       rx_valid, rx_frame_err, rx_busy;
    logic       rx_valid4, rx_frame_err4, rx_busy4;

    int n_checks = 0;
    int n_fail   = 0;

    // Clock counter and pulse monitor.
    int         cyc = 0;
    int         n_valid = 0, n_err = 0, n_both = 0, n_busy = 0;
    int         n_valid4 = 0, n_err4 = 0;
    int         last_cyc = 0, prev_cyc = 0;
    logic [7:0] last_data = 8'h00, prev_data = 8'h00, data4 = 8'h00;
    int         start_cyc = 0;

    always #5 clk = ~clk;

    uart_rx_sampler #(.CLKS_PER_BIT(16)) dut (
        .rx_clk      (clk),
        .rst_n       (rst_n),
        .rx_in       (rx),
        .d_out       (d_out),
        .rx_valid    (rx_valid),
        .rx_frame_err(rx_frame_err),
        .rx_busy     (rx_busy)
    );

    uart_rx_sampler #(.CLKS_PER_BIT(4)) dut4 (
        .rx_clk      (clk),
        .rst_n       (rst_n),
        .rx_in       (rx4),
        .d_out       (d_out4),
        .rx_valid    (rx_valid4),
        .rx_frame_err(rx_frame_err4),
        .rx_busy     (rx_busy4)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid   <= n_valid + 1;
            prev_cyc  <= last_cyc;
            prev_data <= last_data;
            last_cyc  <= cyc;
            last_data <= d_out;
        end
        if (rx_frame_err)             n_err  <= n_err + 1;
        if (rx_valid && rx_frame_err) n_both <= n_both + 1;
        if (rx_busy)                  n_busy <= n_busy + 1;
        if (rx_valid4) begin
            n_valid4 <= n_valid4 + 1;
            data4    <= d_out4;
        end
        if (rx_frame_err4) n_err4 <= n_err4 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one 8N1 frame: a start bit, 8 data bits LSB first, then the stop
    // bit. Each bit lasts cpb clocks. sel4 selects the line of the CPB=4 instance.
    task automatic send(input logic [7:0] data, input logic stop, input int cpb, input bit sel4);
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (sel4) rx4 = bits[i];
            else      rx  = bits[i];
            if (i == 0) start_cyc = cyc;
            repeat (cpb) @(negedge clk);
        end
    endtask

    int v0, e0, b0;

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        rx4   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_d_out",     32'(d_out),        32'h00);
        check("reset_valid",     32'(rx_valid),     32'h0);
        check("reset_frame_err", 32'(rx_frame_err), 32'h0);
        check("reset_busy",      32'(rx_busy),      32'h0);
        check("reset_d_out4",    32'(d_out4),       32'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame A5. rx_valid is seen on the falling edge 155 cycles
        // after the start bit is driven: 1 edge to reach the synchroniser,
        // 2 synchroniser edges, then H = 8 and 9 bits x 16 clocks.
        v0 = n_valid; e0 = n_err;
        send(8'hA5, 1'b1, 16, 1'b0);
        repeat (8) @(negedge clk);
        check("a5_valid_count", 32'(n_valid - v0), 32'd1);
        check("a5_d_out",       32'(d_out),        32'hA5);
        check("a5_captured",    32'(last_data),    32'hA5);
        check("a5_latency",     32'(last_cyc - start_cyc), 32'd155);
        check("a5_no_err",      32'(n_err - e0),   32'd0);

        // Frames 00 and FF back to back, with no idle gap.
        v0 = n_valid;
        send(8'h00, 1'b1, 16, 1'b0);
        send(8'hFF, 1'b1, 16, 1'b0);
        repeat (8) @(negedge clk);
        check("b2b_valid_count", 32'(n_valid - v0),        32'd2);
        check("b2b_first",       32'(prev_data),           32'h00);
        check("b2b_second",      32'(last_data),           32'hFF);
        check("b2b_spacing",     32'(last_cyc - prev_cyc), 32'd160);
        check("b2b_d_out",       32'(d_out),               32'hFF);

        // A 5-cycle low glitch. rx_busy stays high for exactly H = 8 cycles.
        v0 = n_valid; e0 = n_err; b0 = n_busy;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_busy_cycles", 32'(n_busy - b0), 32'd8);
        check("glitch_no_valid",    32'(n_valid - v0), 32'd0);
        check("glitch_no_err",      32'(n_err - e0),   32'd0);
        check("glitch_d_out",       32'(d_out),        32'hFF);
        check("glitch_busy_end",    32'(rx_busy),      32'h0);

        // Frame 3C with a low stop bit, then the line held low for 40 bit times.
        v0 = n_valid; e0 = n_err;
        send(8'h3C, 1'b0, 16, 1'b0);
        repeat (40 * 16) @(negedge clk);
        check("ferr_count",     32'(n_err - e0),   32'd1);
        check("ferr_no_valid",  32'(n_valid - v0), 32'd0);
        check("ferr_d_out",     32'(d_out),        32'hFF);
        check("ferr_busy_held", 32'(rx_busy),      32'h1);
        check("never_both",     32'(n_both),       32'd0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("ferr_busy_release", 32'(rx_busy), 32'h0);
        repeat (16) @(negedge clk);
        v0 = n_valid;
        send(8'h5A, 1'b1, 16, 1'b0);
        repeat (8) @(negedge clk);
        check("after_break_valid", 32'(n_valid - v0), 32'd1);
        check("after_break_d_out", 32'(d_out),        32'h5A);

        // Reset asserted in the middle of data bit 4 of frame 81.
        v0 = n_valid; e0 = n_err;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;                       // bit 0 of 0x81
        repeat (16) @(negedge clk);
        rx = 1'b0;                       // bits 1..4 are 0
        repeat (3 * 16 + 8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        check("rst_mid_d_out", 32'(d_out),        32'h00);
        check("rst_mid_valid", 32'(rx_valid),     32'h0);
        check("rst_mid_err",   32'(rx_frame_err), 32'h0);
        check("rst_mid_busy",  32'(rx_busy),      32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rst_no_valid", 32'(n_valid - v0), 32'd0);
        check("rst_no_err",   32'(n_err - e0),   32'd0);
        check("rst_idle",     32'(rx_busy),      32'h0);
        v0 = n_valid;
        send(8'h81, 1'b1, 16, 1'b0);
        repeat (8) @(negedge clk);
        check("post_rst_valid", 32'(n_valid - v0), 32'd1);
        check("post_rst_d_out", 32'(d_out),        32'h81);

        // Instance with the minimum parameter value, CLKS_PER_BIT = 4.
        send(8'hC3, 1'b1, 4, 1'b1);
        repeat (8) @(negedge clk);
        check("cpb4_valid_count", 32'(n_valid4), 32'd1);
        check("cpb4_d_out",       32'(d_out4),   32'hC3);
        check("cpb4_captured",    32'(data4),    32'hC3);
        check("cpb4_no_err",      32'(n_err4),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
